// File: rtl/cc_miss_req_unit.sv
// ============================================================================
// cc_miss_req_unit : issues one 8x64b WRAP AXI AR burst per cache miss and
//                    queues the miss address for the fill stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cc_miss_req_unit #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               miss_req_i,
  input  logic [31:0]        miss_addr_i,
  output logic               miss_ready_o,
  output logic               mem_arvalid_o,
  input  logic               mem_arready_i,
  output logic [31:0]        mem_araddr_o,
  output logic [3:0]         mem_arlen_o,
  output logic [2:0]         mem_arsize_o,
  output logic [1:0]         mem_arburst_o,
  output logic               miss_addr_fifo_empty_o,
  output logic [31:0]        miss_addr_fifo_rdata_o,
  input  logic               miss_addr_fifo_rden_i,
  output logic [FIFO_AW:0]   outstanding_o
);

  localparam logic [FIFO_AW:0] C_DEPTH = (FIFO_AW+1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    AR_REQ = 1'b1
  } state_e;

  state_e               state_q;
  logic                 arvalid_q;
  logic [31:0]          araddr_q;

  logic [31:0]          mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]     count_q, count_d;

  logic                 w_accept;
  logic                 w_pop;

  assign miss_ready_o = (state_q == IDLE) && (count_q < C_DEPTH);
  assign w_accept     = miss_req_i & miss_ready_o;
  // Pop is judged on the pre-push count, so a pop on empty is dropped even
  // when a push lands in the same cycle.
  assign w_pop        = miss_addr_fifo_rden_i & (count_q != '0);

  assign mem_arvalid_o          = arvalid_q;
  assign mem_araddr_o           = araddr_q;
  assign mem_arlen_o            = 4'd7;
  assign mem_arsize_o           = 3'd3;
  assign mem_arburst_o          = 2'b10;
  assign miss_addr_fifo_empty_o = (count_q == '0);
  assign miss_addr_fifo_rdata_o = mem_q[rd_ptr_q];
  assign outstanding_o          = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_pop)    rd_ptr_d = rd_ptr_q + 1'b1;
    case ({w_accept, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_accept) begin
            araddr_q  <= {miss_addr_i[31:3], 3'b000};
            arvalid_q <= 1'b1;
            state_q   <= AR_REQ;
          end
        end
        AR_REQ: begin
          if (mem_arready_i) begin
            arvalid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          arvalid_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_accept) mem_q[wr_ptr_q] <= miss_addr_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cc_miss_req_unit.sv
// ============================================================================
// tb_cc_miss_req_unit : directed and randomized checks of cc_miss_req_unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cc_miss_req_unit;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              miss_req_i = 1'b0;
  logic [31:0]       miss_addr_i = '0;
  logic              miss_ready_o;
  logic              mem_arvalid_o;
  logic              mem_arready_i = 1'b0;
  logic [31:0]       mem_araddr_o;
  logic [3:0]        mem_arlen_o;
  logic [2:0]        mem_arsize_o;
  logic [1:0]        mem_arburst_o;
  logic              miss_addr_fifo_empty_o;
  logic [31:0]       miss_addr_fifo_rdata_o;
  logic              miss_addr_fifo_rden_i = 1'b0;
  logic [AW:0]       outstanding_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of accepted addresses plus one pending AR.
  logic [31:0] mq[$];
  bit          m_pend = 1'b0;
  logic [31:0] m_araddr = '0;

  cc_miss_req_unit #(.FIFO_DEPTH(DEPTH)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .miss_req_i             (miss_req_i),
    .miss_addr_i            (miss_addr_i),
    .miss_ready_o           (miss_ready_o),
    .mem_arvalid_o          (mem_arvalid_o),
    .mem_arready_i          (mem_arready_i),
    .mem_araddr_o           (mem_araddr_o),
    .mem_arlen_o            (mem_arlen_o),
    .mem_arsize_o           (mem_arsize_o),
    .mem_arburst_o          (mem_arburst_o),
    .miss_addr_fifo_empty_o (miss_addr_fifo_empty_o),
    .miss_addr_fifo_rdata_o (miss_addr_fifo_rdata_o),
    .miss_addr_fifo_rden_i  (miss_addr_fifo_rden_i),
    .outstanding_o          (outstanding_o)
  );

  always #5 clk = ~clk;

  // One clock cycle: drive inputs, update the model at the edge, settle.
  task automatic step(input bit req, input logic [31:0] addr, input bit ar, input bit rd);
    bit m_ready;
    miss_req_i            = req;
    miss_addr_i           = addr;
    mem_arready_i         = ar;
    miss_addr_fifo_rden_i = rd;
    m_ready = !m_pend && (mq.size() < DEPTH);
    @(posedge clk);
    if (rd && mq.size() > 0) void'(mq.pop_front());
    if (m_pend && ar) m_pend = 1'b0;
    else if (req && m_ready) begin
      mq.push_back(addr);
      m_pend   = 1'b1;
      m_araddr = addr & 32'hFFFF_FFF8;
    end
    #1;
    miss_req_i            = 1'b0;
    mem_arready_i         = 1'b0;
    miss_addr_fifo_rden_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    mq.delete();
    m_pend   = 1'b0;
    m_araddr = '0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (mem_arvalid_o !== 1'b0 || mem_araddr_o !== 32'h0) begin
      n_errors++; $display("FAIL reset_ar: arvalid=%b araddr=%h required 0/0", mem_arvalid_o, mem_araddr_o);
    end
    n_checks++;
    if (miss_addr_fifo_empty_o !== 1'b1 || outstanding_o !== 3'd0 || miss_addr_fifo_rdata_o !== 32'h0) begin
      n_errors++; $display("FAIL reset_fifo: empty=%b outst=%0d rdata=%h required 1/0/0",
                           miss_addr_fifo_empty_o, outstanding_o, miss_addr_fifo_rdata_o);
    end
    rst_n = 1'b1;
    mq.delete();
    m_pend = 1'b0;
    #1;
    n_checks++;
    if (miss_ready_o !== 1'b1) begin
      n_errors++; $display("FAIL reset_ready: got %b required 1", miss_ready_o);
    end
  endtask

  task automatic test_single_miss();
    do_reset();
    step(1'b1, 32'h0001_234C, 1'b0, 1'b0);
    n_checks++;
    if (mem_arvalid_o !== 1'b1 || mem_araddr_o !== 32'h0001_2348) begin
      n_errors++; $display("FAIL single_ar: arvalid=%b araddr=%h required 1/00012348", mem_arvalid_o, mem_araddr_o);
    end
    n_checks++;
    if (mem_arlen_o !== 4'd7 || mem_arsize_o !== 3'd3 || mem_arburst_o !== 2'b10) begin
      n_errors++; $display("FAIL single_const: len=%0d size=%0d burst=%0d required 7/3/2",
                           mem_arlen_o, mem_arsize_o, mem_arburst_o);
    end
    n_checks++;
    if (miss_addr_fifo_rdata_o !== 32'h0001_234C || miss_addr_fifo_empty_o !== 1'b0 || outstanding_o !== 3'd1) begin
      n_errors++; $display("FAIL single_fifo: rdata=%h empty=%b outst=%0d required 0001234c/0/1",
                           miss_addr_fifo_rdata_o, miss_addr_fifo_empty_o, outstanding_o);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'hDEAD_0000, 1'b0, 1'b0);
      n_checks++;
      if (mem_arvalid_o !== 1'b1 || mem_araddr_o !== 32'h0001_2348 || miss_ready_o !== 1'b0) begin
        n_errors++; $display("FAIL single_hold: arvalid=%b araddr=%h ready=%b required 1/00012348/0",
                             mem_arvalid_o, mem_araddr_o, miss_ready_o);
      end
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    n_checks++;
    if (mem_arvalid_o !== 1'b0 || miss_ready_o !== 1'b1 || outstanding_o !== 3'd1) begin
      n_errors++; $display("FAIL single_hs: arvalid=%b ready=%b outst=%0d required 0/1/1",
                           mem_arvalid_o, miss_ready_o, outstanding_o);
    end
  endtask

  task automatic test_fill_up();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 32'(i * 256), 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
    end
    n_checks++;
    if (outstanding_o !== 3'd4 || miss_ready_o !== 1'b0) begin
      n_errors++; $display("FAIL full: outst=%0d ready=%b required 4/0", outstanding_o, miss_ready_o);
    end
    step(1'b1, 32'h500, 1'b0, 1'b0);
    n_checks++;
    if (outstanding_o !== 3'd4 || mem_arvalid_o !== 1'b0) begin
      n_errors++; $display("FAIL full_block: outst=%0d arvalid=%b required 4/0", outstanding_o, mem_arvalid_o);
    end
    n_checks++;
    if (miss_addr_fifo_rdata_o !== 32'h100) begin
      n_errors++; $display("FAIL full_head: got %h required 00000100", miss_addr_fifo_rdata_o);
    end
    step(1'b1, 32'h500, 1'b0, 1'b1);
    n_checks++;
    if (outstanding_o !== 3'd3 || miss_addr_fifo_rdata_o !== 32'h200 || miss_ready_o !== 1'b1) begin
      n_errors++; $display("FAIL full_pop: outst=%0d rdata=%h ready=%b required 3/00000200/1",
                           outstanding_o, miss_addr_fifo_rdata_o, miss_ready_o);
    end
    step(1'b1, 32'h500, 1'b0, 1'b0);
    n_checks++;
    if (outstanding_o !== 3'd4 || mem_arvalid_o !== 1'b1 || mem_araddr_o !== 32'h500) begin
      n_errors++; $display("FAIL full_fifth: outst=%0d arvalid=%b araddr=%h required 4/1/00000500",
                           outstanding_o, mem_arvalid_o, mem_araddr_o);
    end
  endtask

  task automatic test_simul_push_pop();
    do_reset();
    step(1'b1, 32'h300, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h400, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h500, 1'b0, 1'b1);
    n_checks++;
    if (outstanding_o !== 3'd2 || miss_addr_fifo_rdata_o !== 32'h400) begin
      n_errors++; $display("FAIL pushpop: outst=%0d rdata=%h required 2/00000400", outstanding_o, miss_addr_fifo_rdata_o);
    end
    step(1'b0, 32'h0, 1'b1, 1'b1);
    n_checks++;
    if (outstanding_o !== 3'd1 || miss_addr_fifo_rdata_o !== 32'h500) begin
      n_errors++; $display("FAIL pushpop_tail: outst=%0d rdata=%h required 1/00000500", outstanding_o, miss_addr_fifo_rdata_o);
    end
  endtask

  task automatic test_pop_empty();
    do_reset();
    step(1'b0, 32'h0, 1'b0, 1'b1);
    n_checks++;
    if (outstanding_o !== 3'd0 || miss_addr_fifo_empty_o !== 1'b1) begin
      n_errors++; $display("FAIL pop_empty: outst=%0d empty=%b required 0/1", outstanding_o, miss_addr_fifo_empty_o);
    end
    step(1'b1, 32'hABC0_0004, 1'b0, 1'b1);
    n_checks++;
    if (outstanding_o !== 3'd1 || miss_addr_fifo_rdata_o !== 32'hABC0_0004 || miss_addr_fifo_empty_o !== 1'b0) begin
      n_errors++; $display("FAIL pop_empty_push: outst=%0d rdata=%h empty=%b required 1/abc00004/0",
                           outstanding_o, miss_addr_fifo_rdata_o, miss_addr_fifo_empty_o);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] a [10];
    int pop_idx = 0;
    do_reset();
    for (int i = 0; i < 10; i++) a[i] = 32'h1000 + 32'(i * 16) + 32'(i);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, a[i], 1'b0, 1'b0);
      if (mq.size() == 2) begin
        n_checks++;
        if (miss_addr_fifo_rdata_o !== a[pop_idx]) begin
          n_errors++; $display("FAIL wrap_order[%0d]: got %h required %h", pop_idx, miss_addr_fifo_rdata_o, a[pop_idx]);
        end
        pop_idx++;
        step(1'b0, 32'h0, 1'b1, 1'b1);
      end else begin
        step(1'b0, 32'h0, 1'b1, 1'b0);
      end
    end
    while (pop_idx < 10 && outstanding_o != 0) begin
      n_checks++;
      if (miss_addr_fifo_rdata_o !== a[pop_idx]) begin
        n_errors++; $display("FAIL wrap_drain[%0d]: got %h required %h", pop_idx, miss_addr_fifo_rdata_o, a[pop_idx]);
      end
      pop_idx++;
      step(1'b0, 32'h0, 1'b0, 1'b1);
    end
    n_checks++;
    if (pop_idx != 10 || miss_addr_fifo_empty_o !== 1'b1) begin
      n_errors++; $display("FAIL wrap_count: popped %0d empty=%b required 10/1", pop_idx, miss_addr_fifo_empty_o);
    end
  endtask

  task automatic test_random();
    bit          have_req = 1'b0;
    logic [31:0] req_addr = '0;
    bit          ar, rd;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      n_checks++;
      if (miss_ready_o !== (!m_pend && mq.size() < DEPTH) || mem_arvalid_o !== m_pend) begin
        n_errors++; $display("FAIL rand_ctl[%0d]: ready=%b arvalid=%b required %b/%b", i, miss_ready_o,
                             mem_arvalid_o, (!m_pend && mq.size() < DEPTH), m_pend);
      end
      n_checks++;
      if (outstanding_o !== 3'(mq.size()) || miss_addr_fifo_empty_o !== (mq.size() == 0)) begin
        n_errors++; $display("FAIL rand_occ[%0d]: outst=%0d empty=%b required %0d", i, outstanding_o,
                             miss_addr_fifo_empty_o, mq.size());
      end
      if (m_pend) begin
        n_checks++;
        if (mem_araddr_o !== m_araddr) begin
          n_errors++; $display("FAIL rand_araddr[%0d]: got %h required %h", i, mem_araddr_o, m_araddr);
        end
      end
      if (mq.size() > 0) begin
        n_checks++;
        if (miss_addr_fifo_rdata_o !== mq[0]) begin
          n_errors++; $display("FAIL rand_rdata[%0d]: got %h required %h", i, miss_addr_fifo_rdata_o, mq[0]);
        end
      end
      if (!have_req && ($urandom_range(0, 3) != 0)) begin
        have_req = 1'b1;
        req_addr = $urandom;
      end
      ar = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 3) == 0);
      if (have_req && !m_pend && mq.size() < DEPTH) begin
        step(1'b1, req_addr, ar, rd);
        have_req = 1'b0;
      end else begin
        step(have_req, req_addr, ar, rd);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b1, 32'h0000_0A10, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h0000_0B20, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h0000_0C30, 1'b0, 1'b0);
    n_checks++;
    if (outstanding_o !== 3'd3 || mem_arvalid_o !== 1'b1) begin
      n_errors++; $display("FAIL mid_pre: outst=%0d arvalid=%b required 3/1", outstanding_o, mem_arvalid_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_arvalid_o !== 1'b0 || miss_addr_fifo_empty_o !== 1'b1 || outstanding_o !== 3'd0) begin
      n_errors++; $display("FAIL mid_async: arvalid=%b empty=%b outst=%0d required 0/1/0",
                           mem_arvalid_o, miss_addr_fifo_empty_o, outstanding_o);
    end
    mq.delete();
    m_pend = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 32'h0000_0D3F, 1'b0, 1'b0);
    n_checks++;
    if (mem_arvalid_o !== 1'b1 || mem_araddr_o !== 32'h0000_0D38 || miss_addr_fifo_rdata_o !== 32'h0000_0D3F ||
        outstanding_o !== 3'd1) begin
      n_errors++; $display("FAIL mid_after: arvalid=%b araddr=%h rdata=%h outst=%0d required 1/00000d38/00000d3f/1",
                           mem_arvalid_o, mem_araddr_o, miss_addr_fifo_rdata_o, outstanding_o);
    end
  endtask

  initial begin
    test_reset();
    test_single_miss();
    test_fill_up();
    test_simul_push_pop();
    test_pop_empty();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cc_miss_req_unit.md
Name: cc_miss_req_unit

Overview:
Upstream neighbour of the cache data-fill stage. Accepts miss requests from the tag-lookup stage and issues one AXI AR burst per miss: 8 beats of 64 bits, WRAP type, critical word first. It also owns the miss-address FIFO that the fill stage pops on the first returning R beat. The FIFO depth bounds the number of outstanding line fills.

Parameters:
FIFO_DEPTH, 4, miss-address FIFO entries; power of 2, >=2; also the max outstanding fills
FIFO_AW, $clog2(FIFO_DEPTH), pointer width (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  reset, asynchronous assert, active-low
miss_req_i  input  1  miss request valid from tag lookup; held until accepted
miss_addr_i  input  32  byte address of the missing access
miss_ready_o  output  1  request accepted this cycle when miss_req_i & miss_ready_o
mem_arvalid_o  output  1  AXI AR valid
mem_arready_i  input  1  AXI AR ready
mem_araddr_o  output  32  AXI AR address
mem_arlen_o  output  4  AXI AR burst length
mem_arsize_o  output  3  AXI AR beat size
mem_arburst_o  output  2  AXI AR burst type
miss_addr_fifo_empty_o  output  1  FIFO empty
miss_addr_fifo_rdata_o  output  32  head entry (first-word fall-through)
miss_addr_fifo_rden_i  input  1  pop request from fill stage
outstanding_o  output  FIFO_AW+1  current FIFO occupancy

Behaviour:
- Reset (async, rst_n=0): state=IDLE; arvalid=0; araddr=0; FIFO pointers and count=0; empty=1; rdata=0. Any pending AR or queued entry is discarded. miss_ready_o=1 immediately after reset deasserts.
- Constant outputs:
  - arlen=4'd7 (8 beats)
  - arsize=3'd3 (8 bytes)
  - arburst=2'b10 (WRAP)
- State machine:
  - IDLE: miss_ready_o = (count < FIFO_DEPTH), combinational. On accept: register araddr={miss_addr_i[31:3],3'b000}, set arvalid=1, push miss_addr_i unmodified into the FIFO, go to AR_REQ. Both updates happen at the same edge.
  - AR_REQ: miss_ready_o=0. arvalid stays 1 and araddr stays stable until mem_arready_i=1 at an edge. At that edge arvalid<=0 and the state returns to IDLE. A new request can be accepted no earlier than the following cycle.
- AXI rules: arvalid never depends combinationally on arready. Once asserted, arvalid is never withdrawn before the handshake.
- FIFO:
  - Circular buffer with FIFO_AW-bit pointers that wrap naturally and an occupancy counter of FIFO_AW+1 bits.
  - rdata always shows the entry at rd_ptr; it is valid whenever empty=0, and the fill stage samples it in the same cycle it asserts rden.
  - Pop is effective only when rden=1 and count>0. Pop on empty is ignored, with no pointer or count change.
  - Push is effective only on an accepted request, so the FIFO never pushes when full.
  - Push and pop in the same cycle: both pointers advance and count is unchanged.
  - Push at count=0 with rden=1 in the same cycle: pop ignored, push succeeds, count=1.
  - A pop in the same cycle as a push at count=FIFO_DEPTH is impossible, because miss_ready_o=0 when full.
- Ordering: FIFO order equals AR issue order. The memory returns R bursts in AR order (same ID).
- outstanding_o equals count. It counts a fill from acceptance until the fill stage pops its address.
- Latency: request accepted at edge N; arvalid=1 and empty=0 visible after edge N. The earliest AR handshake is edge N+1.

Test Plan:
- Single miss: miss_addr_i=0x0001_234C accepted → next cycle arvalid=1, araddr=0x0001_2348, arlen=7, arsize=3, arburst=2; rdata=0x0001_234C, empty=0, outstanding=1. Hold arready=0 for 3 cycles → araddr stable and miss_ready_o=0 throughout. arready=1 → arvalid=0 next cycle, state IDLE.
- Fill up: 4 misses (0x100, 0x200, 0x300, 0x400) each with immediate arready and no pops → outstanding=4, miss_ready_o=0 with a 5th request held. One pop → outstanding=3, rdata=0x200, 5th request accepted next cycle.
- Simultaneous push/pop: count=2, accept miss 0x500 while rden=1 → count stays 2, head advances, 0x500 at tail.
- Pop on empty: rden=1 with empty=1 → count=0, pointers unchanged. A push in the same cycle yields count=1 with rdata equal to the pushed address.
- Wrap-around: 10 push/pop pairs at count≤2 → addresses pop in issue order across pointer wrap, with no loss or duplication.
- Reset mid-operation: rst_n=0 while in AR_REQ with count=3 → arvalid=0, empty=1, outstanding=0 asynchronously. After release a new miss is handled normally.
